// File: rtl/lapido_defs.v
// lapido_defs: shared core-wide width definitions.
`ifndef LAPIDO_DEFS_V
`define LAPIDO_DEFS_V
`define PC_WIDTH 32
`endif

// File: rtl/ex_stage.sv
// ex_stage: execute stage, 1-cycle ALU plus iterative radix-2 MUL/DIV.
// Define LAPIDO_EX_DIV_EN to build the divider for ops 11 (DIV) and 12 (REM).
`include "lapido_defs.v"

module ex_stage (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [4:0]           alu_op,
   input  logic [31:0]          op_a,
   input  logic [31:0]          op_b,
   input  logic [31:0]          in_mem_data,
   input  logic [4:0]           in_reg_dst,
   input  logic [31:0]          in_immediate,
   input  logic [`PC_WIDTH-1:0] in_next_pc,
   input  logic                 is_branch,
   input  logic                 sel_jflag_branch,
   input  logic                 sel_beq_bne,
   input  logic                 sel_jt_jf,
   input  logic                 mem_write,
   input  logic                 reg_write,
   input  logic [1:0]           wb_res_mux,
   output logic                 stall,
   output logic                 out_valid,
   output logic [31:0]          out_alu_res,
   output logic [5:0]           out_flags,
   output logic [`PC_WIDTH-1:0] out_branch_addr,
   output logic [31:0]          out_mem_data,
   output logic [4:0]           out_reg_dst,
   output logic [31:0]          out_immediate,
   output logic [`PC_WIDTH-1:0] out_next_pc,
   output logic                 out_is_branch,
   output logic                 out_sel_jflag_branch,
   output logic                 out_sel_beq_bne,
   output logic                 out_sel_jt_jf,
   output logic                 out_mem_write,
   output logic                 out_reg_write,
   output logic [1:0]           out_wb_res_mux
);

   localparam int PW = `PC_WIDTH;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_NOR   = 5'd5;
   localparam logic [4:0] OP_SLT   = 5'd6;
   localparam logic [4:0] OP_SLL   = 5'd7;
   localparam logic [4:0] OP_SRL   = 5'd8;
   localparam logic [4:0] OP_SRA   = 5'd9;
   localparam logic [4:0] OP_MUL   = 5'd10;
   localparam logic [4:0] OP_DIV   = 5'd11;
   localparam logic [4:0] OP_REM   = 5'd12;
   localparam logic [4:0] OP_PASSB = 5'd13;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t      state, state_nx;
   logic [4:0]  cnt, cnt_nx;
   logic [31:0] mcand, mcand_nx;
   logic [63:0] mprod, mprod_nx;
   logic [32:0] msum;
   logic [63:0] mstep;
   logic [31:0] mres;
   logic [31:0] mag_a, mag_b;
   logic        is_mul, is_div;
   logic        start, busy, done, fire, arith;
   logic [32:0] add33, sub33;
   logic [31:0] fast_res, multi_res, res;
   logic        carry, ovf, zero, neg;

   assign mag_a = op_a[31] ? (~op_a + 32'd1) : op_a;
   assign mag_b = op_b[31] ? (~op_b + 32'd1) : op_b;

   assign is_mul = (alu_op == OP_MUL);

   // Shift-add multiply on magnitudes; sign applied to the low word at the end.
   assign msum  = {1'b0, mprod[63:32]} + (mprod[0] ? {1'b0, mcand} : 33'd0);
   assign mstep = {msum, mprod[31:1]};
   assign mres  = (op_a[31] ^ op_b[31]) ? (~mstep[31:0] + 32'd1) : mstep[31:0];

`ifdef LAPIDO_EX_DIV_EN
   logic [31:0] dvsr, dvsr_nx;
   logic [31:0] drem, drem_nx;
   logic [31:0] dquo, dquo_nx;
   logic [32:0] dshift, dtrial;
   logic [31:0] qstep, rstep, dres;

   assign is_div = (alu_op == OP_DIV) || (alu_op == OP_REM);

   // Restoring division; quotient bits shift in from the dividend register.
   assign dshift = {drem, dquo[31]};
   assign dtrial = dshift - {1'b0, dvsr};
   assign qstep  = {dquo[30:0], ~dtrial[32]};
   assign rstep  = dtrial[32] ? dshift[31:0] : dtrial[31:0];

   always_comb begin
      dres = '0;
      if (op_b == 32'd0)
         dres = (alu_op == OP_DIV) ? 32'hFFFF_FFFF : op_a;
      else if (alu_op == OP_DIV)
         dres = (op_a[31] ^ op_b[31]) ? (~qstep + 32'd1) : qstep;
      else
         dres = op_a[31] ? (~rstep + 32'd1) : rstep;
   end

   assign multi_res = (state == DIV) ? dres : mres;
`else
   assign is_div    = 1'b0;
   assign multi_res = mres;
`endif

   assign busy  = (state != IDLE);
   assign start = ~flush & ~busy & in_valid & (is_mul | is_div);
   assign done  = ~flush & busy & (cnt == 5'd31);
   assign stall = start | (busy & ~flush);
   assign fire  = ~flush & (done | (~busy & in_valid & ~start));

   assign add33 = {1'b0, op_a} + {1'b0, op_b};
   assign sub33 = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      fast_res = '0;
      case (alu_op)
         OP_ADD:   fast_res = add33[31:0];
         OP_SUB:   fast_res = sub33[31:0];
         OP_AND:   fast_res = op_a & op_b;
         OP_OR:    fast_res = op_a | op_b;
         OP_XOR:   fast_res = op_a ^ op_b;
         OP_NOR:   fast_res = ~(op_a | op_b);
         OP_SLT:   fast_res = {31'd0, $signed(op_a) < $signed(op_b)};
         OP_SLL:   fast_res = op_a << op_b[4:0];
         OP_SRL:   fast_res = op_a >> op_b[4:0];
         OP_SRA:   fast_res = $signed(op_a) >>> op_b[4:0];
         OP_PASSB: fast_res = op_b;
         default:  fast_res = '0;
      endcase
   end

   assign res   = done ? multi_res : fast_res;
   assign arith = ~done & ((alu_op == OP_ADD) || (alu_op == OP_SUB));
   assign zero  = (res == 32'd0);
   assign neg   = res[31];

   always_comb begin
      carry = 1'b0;
      ovf   = 1'b0;
      if (arith && alu_op == OP_ADD) begin
         carry = add33[32];
         ovf   = (op_a[31] == op_b[31]) && (add33[31] != op_a[31]);
      end else if (arith) begin
         carry = sub33[32];
         ovf   = (op_a[31] != op_b[31]) && (sub33[31] != op_a[31]);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mcand_nx = mcand;
      mprod_nx = mprod;
`ifdef LAPIDO_EX_DIV_EN
      dvsr_nx  = dvsr;
      drem_nx  = drem;
      dquo_nx  = dquo;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = is_mul ? MUL : DIV;
               cnt_nx   = '0;
               mcand_nx = mag_a;
               mprod_nx = {32'd0, mag_b};
`ifdef LAPIDO_EX_DIV_EN
               dvsr_nx  = mag_b;
               drem_nx  = '0;
               dquo_nx  = mag_a;
`endif
            end
         end
         MUL: begin
            mprod_nx = mstep;
            cnt_nx   = cnt + 5'd1;
            if (done)
               state_nx = IDLE;
         end
         DIV: begin
`ifdef LAPIDO_EX_DIV_EN
            drem_nx = rstep;
            dquo_nx = qstep;
`endif
            cnt_nx = cnt + 5'd1;
            if (done)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mcand <= '0;
         mprod <= '0;
`ifdef LAPIDO_EX_DIV_EN
         dvsr  <= '0;
         drem  <= '0;
         dquo  <= '0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         mcand <= mcand_nx;
         mprod <= mprod_nx;
`ifdef LAPIDO_EX_DIV_EN
         dvsr  <= dvsr_nx;
         drem  <= drem_nx;
         dquo  <= dquo_nx;
`endif
      end
   end

   // Data fields follow the inputs every cycle; side-effecting controls need fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid            <= 1'b0;
         out_alu_res          <= '0;
         out_flags            <= '0;
         out_branch_addr      <= '0;
         out_mem_data         <= '0;
         out_reg_dst          <= '0;
         out_immediate        <= '0;
         out_next_pc          <= '0;
         out_is_branch        <= 1'b0;
         out_sel_jflag_branch <= 1'b0;
         out_sel_beq_bne      <= 1'b0;
         out_sel_jt_jf        <= 1'b0;
         out_mem_write        <= 1'b0;
         out_reg_write        <= 1'b0;
         out_wb_res_mux       <= '0;
      end else begin
         out_valid            <= fire;
         out_alu_res          <= res;
         out_flags            <= {zero | neg, ~zero & ~neg, ovf, carry, neg, zero};
         out_branch_addr      <= in_next_pc + in_immediate[PW-1:0];
         out_mem_data         <= in_mem_data;
         out_reg_dst          <= in_reg_dst;
         out_immediate        <= in_immediate;
         out_next_pc          <= in_next_pc;
         out_is_branch        <= fire & is_branch;
         out_sel_jflag_branch <= sel_jflag_branch;
         out_sel_beq_bne      <= sel_beq_bne;
         out_sel_jt_jf        <= sel_jt_jf;
         out_mem_write        <= fire & mem_write;
         out_reg_write        <= fire & reg_write;
         out_wb_res_mux       <= wb_res_mux;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage, single-cycle ops and MUL/DIV.
module tb_ex_stage;
`ifdef PC_WIDTH
   localparam int PW = `PC_WIDTH;
`else
   localparam int PW = 32;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [4:0]    alu_op = '0;
   logic [31:0]   op_a = '0;
   logic [31:0]   op_b = '0;
   logic [31:0]   in_mem_data = '0;
   logic [4:0]    in_reg_dst = '0;
   logic [31:0]   in_immediate = '0;
   logic [PW-1:0] in_next_pc = '0;
   logic          is_branch = 1'b0;
   logic          sel_jflag_branch = 1'b0;
   logic          sel_beq_bne = 1'b0;
   logic          sel_jt_jf = 1'b0;
   logic          mem_write = 1'b0;
   logic          reg_write = 1'b0;
   logic [1:0]    wb_res_mux = '0;
   logic          stall;
   logic          out_valid;
   logic [31:0]   out_alu_res;
   logic [5:0]    out_flags;
   logic [PW-1:0] out_branch_addr;
   logic [31:0]   out_mem_data;
   logic [4:0]    out_reg_dst;
   logic [31:0]   out_immediate;
   logic [PW-1:0] out_next_pc;
   logic          out_is_branch;
   logic          out_sel_jflag_branch;
   logic          out_sel_beq_bne;
   logic          out_sel_jt_jf;
   logic          out_mem_write;
   logic          out_reg_write;
   logic [1:0]    out_wb_res_mux;

   ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
      .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
      .in_mem_data(in_mem_data), .in_reg_dst(in_reg_dst),
      .in_immediate(in_immediate), .in_next_pc(in_next_pc),
      .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
      .sel_beq_bne(sel_beq_bne), .sel_jt_jf(sel_jt_jf),
      .mem_write(mem_write), .reg_write(reg_write),
      .wb_res_mux(wb_res_mux), .stall(stall),
      .out_valid(out_valid), .out_alu_res(out_alu_res),
      .out_flags(out_flags), .out_branch_addr(out_branch_addr),
      .out_mem_data(out_mem_data), .out_reg_dst(out_reg_dst),
      .out_immediate(out_immediate), .out_next_pc(out_next_pc),
      .out_is_branch(out_is_branch),
      .out_sel_jflag_branch(out_sel_jflag_branch),
      .out_sel_beq_bne(out_sel_beq_bne), .out_sel_jt_jf(out_sel_jt_jf),
      .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
      .out_wb_res_mux(out_wb_res_mux)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [5:0]  f;
   } vec_t;

   vec_t vecs[15];
   int   passed = 0;
   int   total = 0;
   int   n;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else
         passed++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      in_valid = 1'b1;
      alu_op   = op;
      op_a     = a;
      op_b     = b;
   endtask

   task automatic run_multi(output int cyc);
      cyc = 0;
      #1;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         if (stall)
            cyc++;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic do_multi(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
      int c;
      issue(op, a, b);
      run_multi(c);
      check({tag, "_stalls"}, c, 33);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_res"}, out_alu_res, exp);
      tick();
      check({tag, "_pulse"}, out_valid, 0);
   endtask

   task automatic do_fast(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      issue(op, a, b);
      #1;
      check({tag, "_nostall"}, stall, 0);
      tick();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_res"}, out_alu_res, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{5'd1,  32'd10,         32'd3,          32'd7,          6'h10};
      vecs[1]  = '{5'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 6'h10};
      vecs[2]  = '{5'd3,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 6'h22};
      vecs[3]  = '{5'd4,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 6'h22};
      vecs[4]  = '{5'd5,  32'd0,          32'd0,          32'hFFFF_FFFF, 6'h22};
      vecs[5]  = '{5'd6,  32'hFFFF_FFFF, 32'd1,          32'd1,          6'h10};
      vecs[6]  = '{5'd7,  32'd1,          32'h0000_0FFF, 32'h8000_0000, 6'h22};
      vecs[7]  = '{5'd8,  32'h8000_0000, 32'd4,          32'h0800_0000, 6'h10};
      vecs[8]  = '{5'd9,  32'h8000_0000, 32'd4,          32'hF800_0000, 6'h22};
      vecs[9]  = '{5'd13, 32'd5,          32'h0000_1234, 32'h0000_1234, 6'h10};
      vecs[10] = '{5'd14, 32'd5,          32'd6,          32'd0,          6'h21};
      vecs[11] = '{5'd1,  32'd0,          32'd1,          32'hFFFF_FFFF, 6'h26};
      vecs[12] = '{5'd0,  32'hFFFF_FFFF, 32'd1,          32'd0,          6'h25};
      vecs[13] = '{5'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h22};
      vecs[14] = '{5'd31, 32'd1,          32'd1,          32'd0,          6'h21};

      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_res", out_alu_res, 0);
      check("rst_flags", out_flags, 0);
      check("rst_bra", 32'(out_branch_addr), 0);
      check("rst_stall", stall, 0);
      rst = 1'b0;
      tick();

      issue(5'd0, 32'h7FFF_FFFF, 32'd1);
      reg_write    = 1'b1;
      in_reg_dst   = 5'd17;
      wb_res_mux   = 2'd2;
      sel_jt_jf    = 1'b1;
      in_mem_data  = 32'hCAFE_0001;
      in_immediate = 32'd2;
      in_next_pc   = '1;
      #1;
      check("add_stall", stall, 0);
      tick();
      check("add_res", out_alu_res, 32'h8000_0000);
      check("add_flags", out_flags, 6'h2A);
      check("add_valid", out_valid, 1);
      check("add_rw", out_reg_write, 1);
      check("add_dst", out_reg_dst, 17);
      check("add_wbmux", out_wb_res_mux, 2);
      check("add_jtjf", out_sel_jt_jf, 1);
      check("add_mdata", out_mem_data, 32'hCAFE_0001);
      check("add_imm", out_immediate, 2);
      check("bra_wrap", 32'(out_branch_addr), 1);

      in_valid  = 1'b0;
      mem_write = 1'b1;
      is_branch = 1'b1;
      tick();
      check("bub_valid", out_valid, 0);
      check("bub_mw", out_mem_write, 0);
      check("bub_rw", out_reg_write, 0);
      check("bub_br", out_is_branch, 0);
      mem_write = 1'b0;
      is_branch = 1'b0;
      reg_write = 1'b0;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         tick();
         check($sformatf("vec%0d_res", i), out_alu_res, vecs[i].r);
         check($sformatf("vec%0d_flags", i), out_flags, vecs[i].f);
         check($sformatf("vec%0d_valid", i), out_valid, 1);
      end
      in_valid = 1'b0;
      tick();

      reg_write = 1'b1;
      issue(5'd10, 32'hFFFF_FFFD, 32'd7);
      run_multi(n);
      check("mul_stalls", n, 33);
      check("mul_valid", out_valid, 1);
      check("mul_res", out_alu_res, 32'hFFFF_FFEB);
      check("mul_flags", out_flags, 6'h22);
      check("mul_rw", out_reg_write, 1);
      #1;
      check("mul_stall_end", stall, 0);
      tick();
      check("mul_pulse", out_valid, 0);
      reg_write = 1'b0;

      do_multi("mul2", 5'd10, 32'hFFFF_CFC7, 32'h0000_1A85, 32'hFB01_2863);
      do_multi("mul3", 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

`ifdef LAPIDO_EX_DIV_EN
      do_multi("div", 5'd11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
      do_multi("rem", 5'd12, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
      do_multi("div0", 5'd11, 32'd5, 32'd0, 32'hFFFF_FFFF);
      do_multi("rem0", 5'd12, 32'd5, 32'd0, 32'd5);
      do_multi("divov", 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_multi("remov", 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
`else
      do_fast("div_off", 5'd11, 32'hFFFF_FF9C, 32'd7, 32'd0);
      do_fast("rem_off", 5'd12, 32'd5, 32'd0, 32'd0);
      in_valid = 1'b0;
      tick();
`endif

      issue(5'd10, 32'd3, 32'd4);
      mem_write = 1'b1;
      #1;
      repeat (9) tick();
      check("fl_stall10", stall, 1);
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      mem_write = 1'b0;
      check("fl_valid", out_valid, 0);
      check("fl_mw", out_mem_write, 0);
      #1;
      check("fl_stall", stall, 0);
      do_fast("fl_add", 5'd0, 32'd2, 32'd3, 32'd5);
      in_valid = 1'b0;
      tick();

`ifdef LAPIDO_EX_DIV_EN
      issue(5'd11, 32'hFFFF_FF9C, 32'd7);
`else
      issue(5'd10, 32'hFFFF_FF9C, 32'd7);
`endif
      in_mem_data = 32'h0000_DEAD;
      mem_write   = 1'b1;
      #1;
      repeat (5) tick();
      check("rd_stall", stall, 1);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      mem_write = 1'b0;
      check("rd_valid", out_valid, 0);
      check("rd_res", out_alu_res, 0);
      check("rd_flags", out_flags, 0);
      check("rd_mdata", out_mem_data, 0);
      check("rd_bra", 32'(out_branch_addr), 0);
      #1;
      check("rd_stall0", stall, 0);
      do_fast("rd_sub", 5'd1, 32'd5, 32'd5, 32'd0);
      check("rd_sub_flags", out_flags, 6'h21);
      in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
